// File: rtl/dp_cmd_sequencer_if.sv
// Command handshake bundle between a command source (master) and the
// datapath command sequencer (slave).
interface dp_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_fs;
  logic        cmd_c0;
  logic [4:0]  cmd_da;
  logic [4:0]  cmd_sa;
  logic [4:0]  cmd_sb;
  logic [63:0] cmd_imm;
  logic [1:0]  cmd_size;

  modport master (
    output cmd_valid, cmd_op, cmd_fs, cmd_c0, cmd_da, cmd_sa, cmd_sb,
           cmd_imm, cmd_size,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_fs, cmd_c0, cmd_da, cmd_sa, cmd_sb,
           cmd_imm, cmd_size,
    output cmd_ready
  );
endinterface

// File: rtl/dp_cmd_sequencer.sv
// Multi-cycle control-word sequencer for the 64-bit datapath: one command at a
// time, Moore-decoded control outputs from state plus the latched command.
module dp_cmd_sequencer #(
  parameter int RAM_LAT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  dp_cmd_sequencer_if.slave    cmd,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [63:0]          k,
  output logic [4:0]           FS,
  output logic                 C0,
  output logic                 B_Sel,
  output logic                 EN_B,
  output logic                 EN_ALU,
  output logic                 EN_ADDR_ALU,
  output logic                 ram_cs,
  output logic                 ram_write_en,
  output logic                 ram_read_en,
  output logic [1:0]           ramOutsize,
  output logic                 w_reg,
  output logic                 reset_reg,
  output logic [4:0]           SA,
  output logic [4:0]           SB,
  output logic [4:0]           DA
);

  localparam logic [2:0] OP_ALU_RR = 3'b000;
  localparam logic [2:0] OP_ALU_RI = 3'b001;
  localparam logic [2:0] OP_MOV    = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_STORE  = 3'b100;
  localparam logic [3:0] LAT       = 4'(RAM_LAT);
  localparam logic [4:0] ZERO_REG  = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_ADDR,
    S_MEM,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q;
  logic [4:0]  fs_q;
  logic        c0_q;
  logic [4:0]  da_q;
  logic [4:0]  sa_q;
  logic [4:0]  sb_q;
  logic [63:0] imm_q;
  logic [1:0]  size_q;
  logic        err_q;
  logic        accept;
  logic        illegal;
  logic        w_raw;

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign illegal       = (cmd.cmd_op > OP_STORE);
  assign reset_reg     = reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      fs_q    <= '0;
      c0_q    <= 1'b0;
      da_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      imm_q   <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q   <= cmd.cmd_op;
        fs_q   <= cmd.cmd_fs;
        c0_q   <= cmd.cmd_c0;
        da_q   <= cmd.cmd_da;
        sa_q   <= cmd.cmd_sa;
        sb_q   <= cmd.cmd_sb;
        imm_q  <= cmd.cmd_imm;
        size_q <= cmd.cmd_size;
        err_q  <= illegal;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (illegal)
            state_d = S_DONE;
          else if (cmd.cmd_op == OP_LOAD || cmd.cmd_op == OP_STORE)
            state_d = S_ADDR;
          else
            state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_DONE;
      S_ADDR: begin
        state_d = S_MEM;
        cnt_d   = LAT;
      end
      S_MEM: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1)
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    err          = 1'b0;
    k            = '0;
    FS           = '0;
    C0           = 1'b0;
    B_Sel        = 1'b0;
    EN_B         = 1'b0;
    EN_ALU       = 1'b0;
    EN_ADDR_ALU  = 1'b0;
    ram_cs       = 1'b0;
    ram_write_en = 1'b0;
    ram_read_en  = 1'b0;
    ramOutsize   = 2'b11;
    w_raw        = 1'b0;
    SA           = ZERO_REG;
    SB           = ZERO_REG;
    DA           = ZERO_REG;
    unique case (state_q)
      S_EXEC: begin
        if (op_q == OP_MOV) begin
          EN_B  = 1'b1;
          SB    = sb_q;
          DA    = da_q;
          w_raw = 1'b1;
        end else begin
          EN_ALU = 1'b1;
          FS     = fs_q;
          C0     = c0_q;
          SA     = sa_q;
          SB     = sb_q;
          DA     = da_q;
          w_raw  = 1'b1;
          if (op_q == OP_ALU_RI) begin
            B_Sel = 1'b1;
            k     = imm_q;
          end
        end
      end
      S_ADDR, S_MEM: begin
        // Address setup stays on the bus for the whole RAM access.
        EN_ADDR_ALU = 1'b1;
        FS          = 5'b01000;
        B_Sel       = 1'b1;
        SA          = sa_q;
        k           = imm_q;
        ram_cs      = 1'b1;
        ramOutsize  = size_q;
        if (state_q == S_MEM) begin
          if (op_q == OP_STORE) begin
            EN_B         = 1'b1;
            SB           = sb_q;
            ram_write_en = 1'b1;
          end else begin
            ram_read_en = 1'b1;
            DA          = da_q;
            w_raw       = (cnt_q <= 4'd1);
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
    w_reg = w_raw && (DA != ZERO_REG);
  end

endmodule

// File: tb/tb_dp_cmd_sequencer.sv
// Bench for dp_cmd_sequencer: directed and random commands, each cycle's
// control word compared against a per-command schedule derived from op rules.
module tb_dp_cmd_sequencer;
  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dp_cmd_sequencer_if bus ();

  logic        busy, done, err;
  logic [63:0] k;
  logic [4:0]  FS, SA, SB, DA;
  logic        C0, B_Sel, EN_B, EN_ALU, EN_ADDR_ALU;
  logic        ram_cs, ram_write_en, ram_read_en, w_reg, reset_reg;
  logic [1:0]  ramOutsize;

  dp_cmd_sequencer #(.RAM_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .cmd(bus),
    .busy(busy), .done(done), .err(err), .k(k), .FS(FS), .C0(C0),
    .B_Sel(B_Sel), .EN_B(EN_B), .EN_ALU(EN_ALU), .EN_ADDR_ALU(EN_ADDR_ALU),
    .ram_cs(ram_cs), .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ramOutsize(ramOutsize), .w_reg(w_reg), .reset_reg(reset_reg),
    .SA(SA), .SB(SB), .DA(DA)
  );

  logic [98:0] act;
  assign act = {bus.cmd_ready, busy, done, err, k, FS, C0, B_Sel, EN_B, EN_ALU,
                EN_ADDR_ALU, ram_cs, ram_write_en, ram_read_en, ramOutsize,
                w_reg, SA, SB, DA};

  int tests_run = 0;
  int failures  = 0;

  logic [2:0]  c_op;
  logic [4:0]  c_fs, c_da, c_sa, c_sb;
  logic        c_c0;
  logic [63:0] c_imm;
  logic [1:0]  c_size;

  function automatic int cmd_len(input logic [2:0] op);
    if (op <= 3'd2) return 2;
    if (op <= 3'd4) return 2 + LAT;
    return 1;
  endfunction

  // Expected control word t cycles after accept (t=0: idle).
  function automatic logic [98:0] exp_word(input int t);
    logic rdy, bsy, dn, er, ce0, bs, enb, enalu, enaddr, cs, wr, rd, w;
    logic [63:0] kk;
    logic [4:0]  fs, sa, sb, da;
    logic [1:0]  sz;
    int last;
    rdy = (t == 0); bsy = (t != 0); dn = 0; er = 0; ce0 = 0; bs = 0;
    enb = 0; enalu = 0; enaddr = 0; cs = 0; wr = 0; rd = 0; w = 0;
    kk = '0; fs = '0; sa = 5'd31; sb = 5'd31; da = 5'd31; sz = 2'b11;
    last = cmd_len(c_op);
    if (t != 0 && t == last) begin
      dn = 1; er = (c_op > 3'd4);
    end else if (t == 1 && c_op == 3'd2) begin
      enb = 1; sb = c_sb; da = c_da; w = 1;
    end else if (t == 1 && c_op <= 3'd1) begin
      enalu = 1; fs = c_fs; ce0 = c_c0; sa = c_sa; sb = c_sb; da = c_da; w = 1;
      if (c_op == 3'd1) begin bs = 1; kk = c_imm; end
    end else if (t >= 1 && (c_op == 3'd3 || c_op == 3'd4)) begin
      enaddr = 1; fs = 5'b01000; bs = 1; sa = c_sa; kk = c_imm; cs = 1; sz = c_size;
      if (t >= 2 && c_op == 3'd4) begin enb = 1; sb = c_sb; wr = 1; end
      if (t >= 2 && c_op == 3'd3) begin rd = 1; da = c_da; w = (t == last - 1); end
    end
    if (da == 5'd31) w = 0;
    return {rdy, bsy, dn, er, kk, fs, ce0, bs, enb, enalu, enaddr, cs, wr, rd,
            sz, w, sa, sb, da};
  endfunction

  task automatic check(input string tag, input int t, input logic [98:0] got,
                       input logic [98:0] exp);
    tests_run++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int t);
    check(tag, t, act, exp_word(t));
    check({tag, "_excl"}, t,
          99'(($countones({EN_B, EN_ALU, ram_read_en}) > 1) || (ram_write_en && ram_read_en)),
          99'(0));
    check({tag, "_rstreg"}, t, 99'(reset_reg), 99'(reset));
  endtask

  task automatic drive_garbage(input logic valid);
    bus.cmd_valid = valid;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_fs    = 5'($urandom);
    bus.cmd_c0    = 1'($urandom);
    bus.cmd_da    = 5'($urandom);
    bus.cmd_sa    = 5'($urandom);
    bus.cmd_sb    = 5'($urandom);
    bus.cmd_imm   = {$urandom, $urandom};
    bus.cmd_size  = 2'($urandom);
  endtask

  task automatic start_cmd(input logic [2:0] op, input logic [4:0] fs, input logic c0,
                           input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
                           input logic [63:0] imm, input logic [1:0] size);
    @(negedge clock);
    check("idle", 0, act, exp_word(0));
    c_op = op; c_fs = fs; c_c0 = c0; c_da = da; c_sa = sa; c_sb = sb;
    c_imm = imm; c_size = size;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_fs = fs; bus.cmd_c0 = c0;
    bus.cmd_da = da; bus.cmd_sa = sa; bus.cmd_sb = sb; bus.cmd_imm = imm;
    bus.cmd_size = size;
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [4:0] fs,
                         input logic c0, input logic [4:0] da, input logic [4:0] sa,
                         input logic [4:0] sb, input logic [63:0] imm,
                         input logic [1:0] size);
    int last;
    start_cmd(op, fs, c0, da, sa, sb, imm, size);
    last = cmd_len(op);
    for (int t = 1; t <= last; t++) begin
      @(negedge clock);
      check_cycle(tag, t);
      // Commands offered while busy must be ignored.
      drive_garbage((t < last) ? 1'($urandom) : 1'b0);
    end
    $display("[TB] %s op=%0d da=%0d sa=%0d sb=%0d imm=%h cycles=%0d",
             tag, op, da, sa, sb, imm, last);
  endtask

  initial begin
    reset = 1'b1;
    drive_garbage(1'b0);
    c_op = 3'd0; c_fs = '0; c_c0 = 0; c_da = '0; c_sa = '0; c_sb = '0;
    c_imm = '0; c_size = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset", 0, act, exp_word(0));
    check("reset_rstreg", 0, 99'(reset_reg), 99'(1));
    reset = 1'b0;

    run_cmd("alu_ri_x0",  3'b001, 5'b01100, 1'b0, 5'd0,  5'd31, 5'd7,  64'd10, 2'b00);
    run_cmd("alu_ri_x1",  3'b001, 5'b01000, 1'b0, 5'd1,  5'd0,  5'd2,  64'd5,  2'b00);
    run_cmd("mov_x3",     3'b010, 5'b00000, 1'b0, 5'd3,  5'd9,  5'd0,  64'd0,  2'b00);
    run_cmd("store_x1",   3'b100, 5'b00000, 1'b0, 5'd12, 5'd31, 5'd1,  64'd0,  2'b11);
    run_cmd("load_x4",    3'b011, 5'b00000, 1'b0, 5'd4,  5'd31, 5'd5,  64'd0,  2'b11);
    run_cmd("load_x31",   3'b011, 5'b00000, 1'b0, 5'd31, 5'd2,  5'd5,  64'h40, 2'b01);
    run_cmd("alu_rr",     3'b000, 5'b00101, 1'b1, 5'd6,  5'd7,  5'd8,  64'hdead, 2'b00);
    run_cmd("illegal",    3'b111, 5'b00011, 1'b1, 5'd5,  5'd5,  5'd5,  64'hff, 2'b10);

    // Reset during the first MEM cycle of a STORE aborts it.
    start_cmd(3'b100, 5'd0, 1'b0, 5'd2, 5'd3, 5'd4, 64'h18, 2'b10);
    for (int t = 1; t <= 2; t++) begin
      @(negedge clock);
      check_cycle("abort_store", t);
      drive_garbage(1'b0);
    end
    reset = 1'b1;
    #1 check("abort_rstreg", 2, 99'(reset_reg), 99'(1));
    @(negedge clock);
    check("abort_idle", 0, act, exp_word(0));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort_quiet", 0, act, exp_word(0));
    end
    $display("[TB] abort_store reset in first MEM cycle");

    for (int n = 0; n < 30; n++) begin
      logic [4:0] rda;
      rda = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
      run_cmd("rand", 3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom), rda,
              5'($urandom), 5'($urandom), {$urandom, $urandom}, 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
